// File: rtl/fc_tiled.sv
// Fully-connected layer evaluated NUM_LANES outputs at a time from a streamed weight port.
// Inputs, biases and relu_en are captured at start; each group runs BIAS, MAC beats and WB.
module fc_tiled #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int NUM_INPUTS  = 48,
  parameter int NUM_OUTPUTS = 10,
  parameter int NUM_LANES   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              relu_en,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]  in_vec_flat,
  input  logic [NUM_OUTPUTS*DATA_WIDTH-1:0] bias_flat,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]   w_data,
  input  logic                              w_valid,
  output logic                              w_ready,
  output logic [NUM_OUTPUTS*ACC_WIDTH-1:0]  out_vec_flat,
  output logic                              busy,
  output logic                              finish
);

  localparam int DW     = DATA_WIDTH;
  localparam int AW     = ACC_WIDTH;
  localparam int GROUPS = (NUM_OUTPUTS + NUM_LANES - 1) / NUM_LANES;
  localparam int IW     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BIAS = 3'd1,
    S_MAC  = 3'd2,
    S_WB   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                  state_r;
  logic [IW-1:0]           idx_r;
  logic [GW-1:0]           grp_r;
  logic                    relu_r;
  logic signed [DW-1:0]    in_r   [NUM_INPUTS];
  logic signed [DW-1:0]    bias_r [NUM_OUTPUTS];
  logic signed [AW-1:0]    acc_r  [NUM_LANES];
  logic [NUM_OUTPUTS*AW-1:0] out_r;
  logic                    w_ready_r;
  logic                    busy_r;
  logic                    finish_r;

  logic signed [2*DW-1:0]  prod_s [NUM_LANES];
  logic                    beat_s;
  logic                    last_beat_s;

  assign w_ready      = w_ready_r;
  assign out_vec_flat = out_r;
  assign busy         = busy_r;
  assign finish       = finish_r;

  assign beat_s      = w_valid && w_ready_r;
  assign last_beat_s = beat_s && (idx_r == IW'(NUM_INPUTS - 1));

  // Full-precision signed product of the current input element with each weight lane.
  always_comb begin
    for (int l = 0; l < NUM_LANES; l++) begin
      prod_s[l] = in_r[idx_r] * $signed(w_data[l*DW +: DW]);
    end
  end

  // Layer sequencer: operand latching, accumulation, writeback and handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= S_IDLE;
      idx_r     <= {IW{1'b0}};
      grp_r     <= {GW{1'b0}};
      relu_r    <= 1'b0;
      out_r     <= {(NUM_OUTPUTS*AW){1'b0}};
      w_ready_r <= 1'b0;
      busy_r    <= 1'b0;
      finish_r  <= 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) in_r[i] <= {DW{1'b0}};
      for (int j = 0; j < NUM_OUTPUTS; j++) bias_r[j] <= {DW{1'b0}};
      for (int l = 0; l < NUM_LANES; l++) acc_r[l] <= {AW{1'b0}};
    end else begin
      finish_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_INPUTS; i++) in_r[i] <= in_vec_flat[i*DW +: DW];
            for (int j = 0; j < NUM_OUTPUTS; j++) bias_r[j] <= bias_flat[j*DW +: DW];
            relu_r  <= relu_en;
            grp_r   <= {GW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= S_BIAS;
          end
        end
        S_BIAS: begin
          // Padded lanes of the last group start from zero and are never written back.
          for (int l = 0; l < NUM_LANES; l++) begin
            if (int'(grp_r) * NUM_LANES + l < NUM_OUTPUTS)
              acc_r[l] <= AW'(bias_r[int'(grp_r) * NUM_LANES + l]);
            else
              acc_r[l] <= {AW{1'b0}};
          end
          idx_r     <= {IW{1'b0}};
          w_ready_r <= 1'b1;
          state_r   <= S_MAC;
        end
        S_MAC: begin
          if (beat_s) begin
            for (int l = 0; l < NUM_LANES; l++) acc_r[l] <= acc_r[l] + AW'(prod_s[l]);
            if (last_beat_s) begin
              w_ready_r <= 1'b0;
              state_r   <= S_WB;
            end else begin
              idx_r <= idx_r + {{(IW-1){1'b0}}, 1'b1};
            end
          end
        end
        S_WB: begin
          for (int l = 0; l < NUM_LANES; l++) begin
            if (int'(grp_r) * NUM_LANES + l < NUM_OUTPUTS)
              out_r[(int'(grp_r) * NUM_LANES + l)*AW +: AW] <=
                (relu_r && acc_r[l][AW-1]) ? {AW{1'b0}} : acc_r[l];
          end
          if (grp_r == GW'(GROUPS - 1)) begin
            finish_r <= 1'b1;
            state_r  <= S_DONE;
          end else begin
            grp_r   <= grp_r + {{(GW-1){1'b0}}, 1'b1};
            state_r <= S_BIAS;
          end
        end
        S_DONE: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          w_ready_r <= 1'b0;
          busy_r    <= 1'b0;
          state_r   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
